// File: rtl/data_matrix_ir_queue.sv
`default_nettype none
// ============================================================================
// Module      : data_matrix_ir_queue
// Description : DEPTH-entry instruction-register FIFO for the LC-3 datapath.
//               Captures bus words on ld_ir, presents the oldest word as ir,
//               reports occupancy and sticky overflow/underflow, and supports
//               a synchronous flush for branch/interrupt redirection.
// Revision    : 1.0 - initial release
// ============================================================================
module data_matrix_ir_queue #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] bus,
    input  logic          ld_ir,
    input  logic          ir_rd,
    input  logic          flush,
    output logic [DW-1:0] ir,
    output logic [3:0]    opcode,
    output logic          ir_vld,
    output logic          ir_full,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_udf;

    logic          w_vld;
    logic          w_full;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Status derived purely from registered occupancy.
    assign w_vld  = (r_count != '0);
    assign w_full = (r_count == C_DEPTH);

    // A push into a full queue is still taken when the head is being
    // consumed in the same cycle; a pop never bypasses a same-cycle push.
    assign w_push_ok = ld_ir && (!w_full || ir_rd);
    assign w_pop_ok  = ir_rd && w_vld;

    // Storage array; contents need no reset because ir is gated by ir_vld.
    always_ff @(posedge clk) begin
        if (!flush && w_push_ok) begin
            r_mem[r_wr_ptr] <= bus;
        end
    end

    // Pointers, occupancy and sticky error flags; flush has top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (ld_ir && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (ir_rd && !w_vld) begin
                r_udf <= 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Head word is forced to zero whenever the queue is empty.
    assign ir      = w_vld ? r_mem[r_rd_ptr] : '0;
    assign opcode  = ir[15:12];
    assign ir_vld  = w_vld;
    assign ir_full = w_full;
    assign count   = r_count;
    assign ovf     = r_ovf;
    assign udf     = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_data_matrix_ir_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_matrix_ir_queue
// Description : Scoreboard bench for data_matrix_ir_queue. Stimulus pushes
//               expected words; a monitor pops and compares on every
//               accepted read of the head word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_matrix_ir_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic        ld_ir;
    logic        ir_rd;
    logic        flush;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic        ir_vld;
    logic        ir_full;
    logic [2:0]  count;
    logic        ovf;
    logic        udf;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sbq[$];

    data_matrix_ir_queue #(.DW(16), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ld_ir   (ld_ir),
        .ir_rd   (ir_rd),
        .flush   (flush),
        .ir      (ir),
        .opcode  (opcode),
        .ir_vld  (ir_vld),
        .ir_full (ir_full),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; exp_push queues the word as an expected pop.
    task automatic cyc(input logic l, input logic [15:0] d, input logic r,
                       input logic f, input logic exp_push);
        ld_ir = l;
        bus   = d;
        ir_rd = r;
        flush = f;
        if (f) sbq.delete();
        if (exp_push) sbq.push_back(d);
        @(posedge clk);
        #1;
        ld_ir = 1'b0;
        ir_rd = 1'b0;
        flush = 1'b0;
        bus   = 16'h0000;
    endtask

    // Monitor: every accepted pop must present the oldest expected word.
    always @(negedge clk) begin
        if (!rst && ir_rd && ir_vld && !flush) begin
            if (sbq.size() == 0) begin
                chk("pop_unexpected", {16'h0, ir}, 32'hDEAD_BEEF);
            end else begin
                chk("pop_data", {16'h0, ir}, {16'h0, sbq.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; bus = 16'hFFFF; ld_ir = 1'b1; ir_rd = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir",     ir,     0);
        chk("rst_opcode", opcode, 0);
        chk("rst_vld",    ir_vld, 0);
        chk("rst_count",  count,  0);
        chk("rst_ovf",    ovf,    0);
        chk("rst_udf",    udf,    0);
        rst = 1'b0; ld_ir = 1'b0; bus = 16'h0;
        @(posedge clk); #1;

        // First push visible one cycle later.
        cyc(1, 16'h1234, 0, 0, 1);
        chk("push1_ir",     ir,     16'h1234);
        chk("push1_opcode", opcode, 4'h1);
        chk("push1_count",  count,  1);
        cyc(0, 0, 1, 0, 0);
        chk("pop1_vld", ir_vld, 0);
        chk("pop1_ir",  ir,     0);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 4; i++) cyc(1, 16'hA000 + 16'(i), 0, 0, 1);
        chk("fill_full",  ir_full, 1);
        chk("fill_count", count,   4);
        cyc(1, 16'hA005, 0, 0, 0);
        chk("ovf_set",   ovf,   1);
        chk("ovf_count", count, 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("drain_vld",  ir_vld, 0);
        chk("drain_ir",   ir,     0);
        chk("ovf_sticky", ovf,    1);
        cyc(0, 0, 0, 1, 0);
        chk("flush_ovf", ovf, 0);

        // Simultaneous push/pop while full.
        for (int i = 1; i <= 4; i++) cyc(1, 16'hA000 + 16'(i), 0, 0, 1);
        cyc(1, 16'hB000, 1, 0, 1);
        chk("pp_ir",    ir,      16'hA002);
        chk("pp_count", count,   4);
        chk("pp_full",  ir_full, 1);
        chk("pp_ovf",   ovf,     0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        chk("pp_tail_ir", ir,    16'hB000);
        chk("pp_tail_ct", count, 1);
        cyc(0, 0, 1, 0, 0);
        chk("pp_empty", ir_vld, 0);

        // Underflow, then pop with push on empty (no bypass).
        cyc(0, 0, 1, 0, 0);
        chk("udf_set",   udf,   1);
        chk("udf_count", count, 0);
        cyc(0, 0, 0, 1, 0);
        chk("udf_clr", udf, 0);
        cyc(1, 16'hC0DE, 1, 0, 1);
        chk("udfpush_udf",   udf,   1);
        chk("udfpush_count", count, 1);
        chk("udfpush_ir",    ir,    16'hC0DE);

        // Flush priority over same-cycle push and pop.
        cyc(0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) cyc(1, 16'hD000 + 16'(i), 0, 0, 1);
        cyc(1, 16'hD005, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("pre_flush_count", count, 3);
        chk("pre_flush_ovf",   ovf,   1);
        cyc(1, 16'hE000, 1, 1, 0);
        chk("flush_count", count,  0);
        chk("flush_vld",   ir_vld, 0);
        chk("flush_ovf2",  ovf,    0);
        chk("flush_udf",   udf,    0);
        cyc(1, 16'hE001, 0, 0, 1);
        chk("post_flush_ir",  ir,     16'hE001);
        chk("post_flush_vld", ir_vld, 1);
        cyc(0, 0, 1, 0, 0);

        // Back-to-back push/pop pairs across pointer wrap.
        cyc(1, 16'hF000, 0, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 16'hF000 + 16'(i), 1, 0, 1);
            chk("wrap_count", count, 1);
        end
        cyc(0, 0, 1, 0, 0);
        chk("wrap_empty", ir_vld, 0);
        chk("sb_drained", sbq.size(), 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
